pipeline_stage_register: RTL and testbench
==========================================

// Module: pipeline_stage_register
// PURPOSE
// - Generic, parametrised inter-stage register for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Replaces the four hand-written stage registers with one block carrying an opaque packed payload.
// - Adds a valid/ready handshake, stall, flush with bubble insertion, an optional skid buffer
//   and an occupancy output for the dataflow bench.
// PARAMETERS
// - DataWidth    64    payload width in bits; instantiate with $bits(<stage struct>)
// - BubbleValue  '0    payload value loaded on reset/flush; a NOP-encoded stage struct
// PORTS
// - clock      in   1          single clock; all state updates on rising edge
// - reset      in   1          synchronous, active-high
// - stall      in   1          hazard unit: hold contents, accept nothing
// - flush      in   1          hazard unit: discard contents, insert bubble
// - valid_in   in   1          upstream stage presents payload
// - ready_out  out  1          this stage can accept payload this cycle
// - data_in    in   DataWidth  upstream payload
// - valid_out  out  1          payload on data_out is valid
// - ready_in   in   1          downstream stage consumes payload this cycle
// - data_out   out  DataWidth  registered payload to downstream
// - occupancy  out  2          entries held: 0..1, or 0..2 with skid
// BEHAVIOUR
// - Reset: valid_out=0, data_out=BubbleValue, occupancy=0, skid entry empty; ready_out=0 while reset=1.
// - Accept: valid_in & ready_out at an edge. Emit: valid_out & ready_in at an edge.
// - Priority per cycle: reset > flush > stall > accept/emit.
// - flush=1: next cycle valid_out=0, data_out=BubbleValue, all entries dropped.
//   ready_out=0 in the flush cycle, so the upstream payload is never accepted.
// - stall=1, flush=0: all state held, ready_out=0; emission is also suppressed.
// - Base mode (no skid): single entry; ready_out = ~stall & ~flush & (~valid_out | ready_in).
//   Latency 1 cycle in->out. Full throughput (1 payload/cycle) when ready_in stays high.
//   Accept and emit in the same cycle: new payload replaces the old one, valid_out stays 1.
//   Emit without accept: valid_out->0, data_out holds its last value (no bubble load).
// - Payload is never modified. Ordering is strict FIFO. No payload is dropped except on flush/reset.
// - occupancy = valid_out + skid_valid; never exceeds 1 in base mode.
// CONFIGURATION
// - Macro PIPELINE_SKID_BUFFER_EN.
// - Defined: second (skid) entry behind the main register.
//   - ready_out becomes a registered ~skid_valid, gated only by stall/flush/reset.
//     No combinational ready_in->ready_out path.
//   - Accept while main is full and ready_in=0: payload goes to skid; occupancy=2; next cycle ready_out=0.
//   - Emit while skid is full: skid moves to main the same edge; skid_valid->0.
//   - Flush clears both entries.
//   - Latency is still 1 cycle when skid is empty.
// - Undefined: base mode above; skid logic and its state are absent.
// STRUCTURE
// - Package pipeline_pkg:
//   - typedef stage_ctrl_t {stall, flush}, one per stage from the hazard unit
//   - typedef occupancy_t logic[1:0]
//   - localparam NOP instruction_t constant, used to build BubbleValue
// - Stage structs stay in the existing testbench/core packages; this block stays payload-agnostic.
// - Sub-module pipeline_skid_entry: one valid+payload register with load/clear.
//   Instantiated once for main and once for skid (only under PIPELINE_SKID_BUFFER_EN).
// TESTING (DataWidth=32, BubbleValue=32'h0000_0013)
// - Reset mid-stream:
//   - with valid_out=1 and data_out=32'hA5A5_0001, pulse reset 1 cycle
//     -> valid_out=0, data_out=32'h13, occupancy=0
// - Streaming:
//   - valid_in=1, ready_in=1, data_in=1,2,3,4 on consecutive cycles
//     -> data_out=1,2,3,4 one cycle later each; ready_out held 1
// - Backpressure:
//   - hold ready_in=0 after accepting 32'h10
//   - base: ready_out=0, data_out stays 32'h10
//   - skid: 32'h11 is also accepted, occupancy=2, then 32'h10 and 32'h11 emit in order
// - Stall:
//   - stall=1 for 3 cycles with valid_out=1, data_out=32'h20, ready_in=1
//     -> ready_out=0, data_out=32'h20 and valid_out=1 unchanged, nothing emitted
// - Flush vs accept:
//   - flush=1 with valid_in=1, data_in=32'h30
//     -> ready_out=0 that cycle; next cycle valid_out=0, data_out=32'h13, occupancy=0
// - Flush with stall:
//   - flush=1 and stall=1 together, occupancy=2 (skid)
//     -> flush wins; both entries cleared next cycle

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the core's inter-stage registers.
// Holds the hazard-unit control bundle, the occupancy type and the NOP
// encoding that stage structs use to build their bubble value.
package pipeline_pkg;

    // Per-stage hazard controls driven by the hazard unit
    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    // Number of payloads held by one stage register (0..2)
    typedef logic [1:0] occupancy_t;

    typedef logic [31:0] instruction_t;

    // addi x0, x0, 0: the canonical NOP used to fill bubbles
    localparam instruction_t NOP = 32'h0000_0013;

    // Sum of the occupied entries of a stage register
    function automatic occupancy_t count_entries(input logic main_v, input logic skid_v);
        return occupancy_t'({1'b0, main_v}) + occupancy_t'({1'b0, skid_v});
    endfunction

endpackage

// File: rtl/pipeline_skid_entry.sv
// One valid+payload storage entry of a stage register.
// clear_i empties the entry and parks the bubble payload on it, load_i
// captures data_i, unload_i drops the valid while keeping the payload.
module pipeline_skid_entry #(
    parameter int                   DataWidth   = 64,
    parameter logic [DataWidth-1:0] BubbleValue = '0
) (
    input  logic                 clock,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 unload_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o
);

    logic                 valid_q;
    logic [DataWidth-1:0] data_q;

    // Clear beats load, load beats unload; otherwise the entry holds
    always_ff @(posedge clock) begin
        if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= BubbleValue;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// Generic inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying an
// opaque payload with valid/ready handshake, stall and flush-with-bubble.
// Optional feature: define PIPELINE_SKID_BUFFER_EN to add a second (skid)
// entry behind the main register and make ready_out a registered signal
// with no combinational path from ready_in.
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int                   DataWidth   = 64,
    parameter logic [DataWidth-1:0] BubbleValue = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [DataWidth-1:0] data_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [DataWidth-1:0] data_out,
    output occupancy_t           occupancy
);

    stage_ctrl_t          ctrl;
    logic                 clear;
    logic                 advance;
    logic                 emit;
    logic                 accept;
    logic                 main_valid;
    logic                 main_load;
    logic                 main_unload;
    logic [DataWidth-1:0] main_data_in;
    logic [DataWidth-1:0] main_data;

    assign ctrl    = {stall, flush};
    // Reset and flush both drop every entry; stall freezes everything else
    assign clear   = reset | ctrl.flush;
    assign advance = ~clear & ~ctrl.stall;
    assign emit    = advance & main_valid & ready_in;
    assign accept  = valid_in & ready_out;

`ifdef PIPELINE_SKID_BUFFER_EN
    logic                 skid_valid;
    logic                 skid_valid_d;
    logic                 skid_load;
    logic                 skid_unload;
    logic                 ready_q;
    logic [DataWidth-1:0] skid_data;

    // ready_q mirrors ~skid_valid from a flop, so ready_in never reaches ready_out
    assign ready_out    = advance & ready_q;

    // Main refills from skid when it drains; otherwise from upstream.
    // While skid is full ready_q is low, so accept and skid refill never collide.
    assign main_load    = (accept & (~main_valid | emit)) | (emit & skid_valid);
    assign main_data_in = skid_valid ? skid_data : data_in;
    assign main_unload  = emit & ~main_load;
    assign skid_load    = accept & main_valid & ~emit;
    assign skid_unload  = emit & skid_valid;

    // Next-state of the skid valid bit, used to pre-compute ready
    always_comb begin
        skid_valid_d = skid_valid;
        if (clear) begin
            skid_valid_d = 1'b0;
        end else if (skid_load) begin
            skid_valid_d = 1'b1;
        end else if (skid_unload) begin
            skid_valid_d = 1'b0;
        end
    end

    // Registered ready: open whenever the skid entry will be empty
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ~skid_valid_d;
        end
    end

    pipeline_skid_entry #(
        .DataWidth   (DataWidth),
        .BubbleValue (BubbleValue)
    ) u_skid (
        .clock    (clock),
        .clear_i  (clear),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .data_i   (data_in),
        .valid_o  (skid_valid),
        .data_o   (skid_data)
    );

    assign occupancy = count_entries(main_valid, skid_valid);
`else
    // Single entry: free, or being drained by downstream this cycle
    assign ready_out    = advance & (~main_valid | ready_in);
    assign main_load    = accept;
    assign main_data_in = data_in;
    assign main_unload  = emit & ~accept;

    assign occupancy = count_entries(main_valid, 1'b0);
`endif

    pipeline_skid_entry #(
        .DataWidth   (DataWidth),
        .BubbleValue (BubbleValue)
    ) u_main (
        .clock    (clock),
        .clear_i  (clear),
        .load_i   (main_load),
        .unload_i (main_unload),
        .data_i   (main_data_in),
        .valid_o  (main_valid),
        .data_o   (main_data)
    );

    assign valid_out = main_valid;
    assign data_out  = main_data;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Self-checking bench for pipeline_stage_register (DataWidth=32, bubble=NOP).
// Works in both builds; define PIPELINE_SKID_BUFFER_EN for the skid variant.
module tb_pipeline_stage_register;

    localparam int          DW  = 32;
    localparam logic [31:0] BUB = 32'h0000_0013;
`ifdef PIPELINE_SKID_BUFFER_EN
    localparam int          CAP = 2;
`else
    localparam int          CAP = 1;
`endif

    logic          clock = 1'b0;
    logic          reset, stall, flush, valid_in, ready_in;
    logic          ready_out, valid_out;
    logic [DW-1:0] data_in, data_out;
    logic [1:0]    occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    pipeline_stage_register #(
        .DataWidth   (DW),
        .BubbleValue (BUB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .occupancy (occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of held payloads bounded by CAP
    logic [31:0] mq[$];
    logic [31:0] m_last = BUB;
    bit          m_live = 1'b0;

    function automatic logic m_ready();
        if (reset || stall || flush) return 1'b0;
        if (CAP == 1) return (mq.size() == 0) || ready_in;
        return mq.size() < CAP;
    endfunction

    always @(posedge clock) begin
        bit          acc;
        bit          emt;
        logic [31:0] popped;
        if (reset || flush) begin
            mq.delete();
            m_last = BUB;
            m_live = 1'b1;
        end else if (!stall) begin
            acc = valid_in && m_ready();
            emt = (mq.size() > 0) && ready_in;
            if (emt) begin
                popped = mq.pop_front();
                if (mq.size() == 0) m_last = popped;
            end
            if (acc) mq.push_back(data_in);
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("m_valid_out", 32'(valid_out), 32'(mq.size() > 0));
            chk("m_data_out",  data_out, (mq.size() > 0) ? mq[0] : m_last);
            chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
            chk("m_ready_out", 32'(ready_out), 32'(m_ready()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data",  data_out, 32'h13);
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd0);
        reset = 1'b0;

        // Streaming 1..4 at full throughput
        ready_in = 1'b1; valid_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            data_in = 32'(k);
            @(negedge clock);
            chk("stream_ready", 32'(ready_out), 32'd1);
            tick();
            chk("stream_data",  data_out, 32'(k));
            chk("stream_valid", 32'(valid_out), 32'd1);
        end
        valid_in = 1'b0;
        tick();
        chk("drain_valid", 32'(valid_out), 32'd0);
        chk("drain_hold",  data_out, 32'd4);

        // Reset mid-stream
        valid_in = 1'b1; data_in = 32'hA5A5_0001; ready_in = 1'b0;
        tick();
        chk("mid_data", data_out, 32'hA5A5_0001);
        valid_in = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_data",  data_out, 32'h13);
        chk("mid_rst_occ",   32'(occupancy), 32'd0);

        // Backpressure
        valid_in = 1'b1; data_in = 32'h10; ready_in = 1'b0;
        tick();
        chk("bp_first", data_out, 32'h10);
        data_in = 32'h11;
        tick();
`ifdef PIPELINE_SKID_BUFFER_EN
        chk("bp_occ2",   32'(occupancy), 32'd2);
        chk("bp_head",   data_out, 32'h10);
        chk("bp_ready0", 32'(ready_out), 32'd0);
        valid_in = 1'b0; ready_in = 1'b1;
        tick();
        chk("bp_second", data_out, 32'h11);
        chk("bp_occ1",   32'(occupancy), 32'd1);
        tick();
        chk("bp_empty",  32'(valid_out), 32'd0);
        chk("bp_hold",   data_out, 32'h11);
`else
        chk("bp_occ1",   32'(occupancy), 32'd1);
        chk("bp_head",   data_out, 32'h10);
        chk("bp_ready0", 32'(ready_out), 32'd0);
        valid_in = 1'b0; ready_in = 1'b1;
        tick();
        chk("bp_empty",  32'(valid_out), 32'd0);
        chk("bp_hold",   data_out, 32'h10);
`endif

        // Stall holds everything, even with ready_in high
        valid_in = 1'b1; data_in = 32'h20; ready_in = 1'b0;
        tick();
        valid_in = 1'b0; stall = 1'b1; ready_in = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("stall_ready", 32'(ready_out), 32'd0);
            tick();
            chk("stall_data",  data_out, 32'h20);
            chk("stall_valid", 32'(valid_out), 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("stall_release", 32'(valid_out), 32'd0);

        // Flush versus an offered payload
        valid_in = 1'b1; data_in = 32'h2F; ready_in = 1'b0;
        tick();
        data_in = 32'h30; flush = 1'b1;
        @(negedge clock);
        chk("flush_ready", 32'(ready_out), 32'd0);
        tick();
        flush = 1'b0; valid_in = 1'b0;
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_data",  data_out, 32'h13);
        chk("flush_occ",   32'(occupancy), 32'd0);

        // Flush together with stall on a full register
        valid_in = 1'b1; data_in = 32'h40; ready_in = 1'b0;
        tick();
        data_in = 32'h41;
        tick();
        chk("fs_occ_full", 32'(occupancy), 32'(CAP));
        valid_in = 1'b0; flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        chk("fs_occ",   32'(occupancy), 32'd0);
        chk("fs_valid", 32'(valid_out), 32'd0);
        chk("fs_data",  data_out, 32'h13);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) != 0);
            data_in  = $urandom;
            stall    = ($urandom_range(0, 19) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            tick();
        end
        valid_in = 1'b0; ready_in = 1'b1; stall = 1'b0; flush = 1'b0; reset = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
